// File: rtl/gameplay_pkg.sv
// Shared constants, direction/status encodings and helpers for the gameplay datapath.
// Geometry constants here are defaults; the top module re-exposes them as parameters.
package gameplay_pkg;

  localparam int unsigned SCREEN_W      = 160;
  localparam int unsigned BLOCK_W       = 16;
  localparam int unsigned ROW_H         = 8;
  localparam int unsigned N_ROWS        = 15;
  localparam int unsigned Y_BASE        = 112;
  localparam int unsigned START_CHANCES = 3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    PLAYING = 2'b01,
    OVER    = 2'b10
  } game_status_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gameplay_datapath_if.sv
// Control pulses from the gameplay FSM and the datapath's state/judge outputs.
interface gameplay_datapath_if;

  logic       ld_x;
  logic       ld_y;
  logic       ld_d;
  logic       enable;
  logic       save_x;
  logic       inc_row;
  logic       inc_score;
  logic       dec_chances;
  logic [7:0] x;
  logic [6:0] y;
  logic [7:0] prev_x;
  logic [3:0] row;
  logic [7:0] score;
  logic [1:0] chances;
  logic       move_tick;
  logic       c;
  logic       o;

  modport master (
    output ld_x, ld_y, ld_d, enable, save_x, inc_row, inc_score, dec_chances,
    input  x, y, prev_x, row, score, chances, move_tick, c, o
  );

  modport slave (
    input  ld_x, ld_y, ld_d, enable, save_x, inc_row, inc_score, dec_chances,
    output x, y, prev_x, row, score, chances, move_tick, c, o
  );

endinterface

// File: rtl/move_rate_divider.sv
// Tick counter pacing block movement; optional score-based speedup under GAMEPLAY_SPEEDUP_EN.
// The active divisor is latched only when the count restarts, so an interval is never cut short.
module move_rate_divider #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] score,
  output logic       tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] div_q, div_d;
  logic [CntW-1:0] div_next;

`ifdef GAMEPLAY_SPEEDUP_EN
  logic [1:0] shift;

  always_comb begin
    shift    = (score[7:3] > 5'd3) ? 2'd3 : score[4:3];
    div_next = CntW'(TICK_DIV) >> shift;
    if (div_next == '0) begin
      div_next = CntW'(1);
    end
  end
`else
  logic unused_score;
  assign unused_score = ^score;
  assign div_next     = CntW'(TICK_DIV);
`endif

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
      div_d = div_next;
    end else if (enable) begin
      if (cnt_q == div_q - CntW'(1)) begin
        cnt_d = '0;
        div_d = div_next;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      div_q <= CntW'(TICK_DIV);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/gameplay_datapath.sv
// Datapath slave of the gameplay FSM: block position/bounce, row, score and chances.
// Optional macro GAMEPLAY_SPEEDUP_EN (in move_rate_divider) speeds movement up with score.
module gameplay_datapath #(
  parameter int unsigned SCREEN_W      = gameplay_pkg::SCREEN_W,
  parameter int unsigned BLOCK_W       = gameplay_pkg::BLOCK_W,
  parameter int unsigned ROW_H         = gameplay_pkg::ROW_H,
  parameter int unsigned N_ROWS        = gameplay_pkg::N_ROWS,
  parameter int unsigned Y_BASE        = gameplay_pkg::Y_BASE,
  parameter int unsigned START_CHANCES = gameplay_pkg::START_CHANCES,
  parameter int unsigned TICK_DIV      = 500000
) (
  input  logic                clk,
  input  logic                resetn,
  gameplay_datapath_if.slave  dp
);

  import gameplay_pkg::*;

  localparam logic [7:0] MaxX = 8'(SCREEN_W - BLOCK_W);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [7:0] prev_x_q, prev_x_d;
  logic [3:0] row_q, row_d;
  logic [7:0] score_q, score_d;
  logic [1:0] chances_q, chances_d;
  dir_e       dir_q, dir_d;
  logic       move_tick_q;

  logic       tick;
  logic       new_game;
  logic       move_en;
  logic [3:0] row_eff;
  logic [8:0] diff;
  logic [8:0] adiff;

  // New game is only reachable once chances are exhausted.
  assign new_game = dp.ld_x & ~(|chances_q);
  assign move_en  = dp.enable & ~dp.ld_x & ~dp.ld_d;

  move_rate_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_move_rate_divider (
    .clk    (clk),
    .resetn (resetn),
    .clear  (dp.ld_x),
    .enable (move_en),
    .score  (score_q),
    .tick   (tick)
  );

  always_comb begin
    x_d       = x_q;
    dir_d     = dir_q;
    y_d       = y_q;
    prev_x_d  = prev_x_q;
    row_d     = row_q;
    score_d   = score_q;
    chances_d = chances_q;
    row_eff   = new_game ? 4'd0 : row_q;

    if (dp.ld_x) x_d = 8'd0;
    if (dp.ld_d) dir_d = DIR_RIGHT;
    if (tick) begin
      if (dir_q == DIR_RIGHT) begin
        if (x_q == MaxX) begin
          dir_d = DIR_LEFT;
          x_d   = x_q - 8'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end else begin
        if (x_q == 8'd0) begin
          dir_d = DIR_RIGHT;
          x_d   = 8'd1;
        end else begin
          x_d = x_q - 8'd1;
        end
      end
    end

    if (dp.ld_y) y_d = 7'(Y_BASE - 32'(row_eff) * ROW_H);
    if (dp.save_x) prev_x_d = x_q;
    if (dp.inc_row) row_d = (row_q == 4'(N_ROWS - 1)) ? 4'd0 : row_q + 4'd1;
    if (dp.inc_score) score_d = sat_inc8(score_q);
    if (dp.dec_chances && chances_q != 2'd0) chances_d = chances_q - 2'd1;

    if (new_game) begin
      row_d     = 4'd0;
      score_d   = 8'd0;
      chances_d = 2'(START_CHANCES);
      prev_x_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q         <= 8'd0;
      dir_q       <= DIR_RIGHT;
      y_q         <= 7'(Y_BASE);
      prev_x_q    <= 8'd0;
      row_q       <= 4'd0;
      score_q     <= 8'd0;
      chances_q   <= 2'(START_CHANCES);
      move_tick_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      dir_q       <= dir_d;
      y_q         <= y_d;
      prev_x_q    <= prev_x_d;
      row_q       <= row_d;
      score_q     <= score_d;
      chances_q   <= chances_d;
      move_tick_q <= tick;
    end
  end

  // Zero-extended subtraction keeps the true signed distance without wrap.
  assign diff  = {1'b0, x_q} - {1'b0, prev_x_q};
  assign adiff = diff[8] ? (9'd0 - diff) : diff;

  assign dp.x         = x_q;
  assign dp.y         = y_q;
  assign dp.prev_x    = prev_x_q;
  assign dp.row       = row_q;
  assign dp.score     = score_q;
  assign dp.chances   = chances_q;
  assign dp.move_tick = move_tick_q;
  assign dp.c         = (chances_q != 2'd0);
  assign dp.o         = (adiff < 9'(BLOCK_W));

endmodule

// File: tb/tb_gameplay_datapath.sv
// Self-checking bench for gameplay_datapath: behavioural model compared every cycle,
// plus directed literal checks on movement, bounce, overlap, counters and reset.
`timescale 1ns/1ps
module tb_gameplay_datapath;

  localparam int unsigned TICK_DIV      = 2;
  localparam int unsigned SCREEN_W      = 32;
  localparam int unsigned BLOCK_W       = 8;
  localparam int unsigned ROW_H         = 8;
  localparam int unsigned N_ROWS        = 15;
  localparam int unsigned Y_BASE        = 112;
  localparam int unsigned START_CHANCES = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  gameplay_datapath_if dp_if ();

  gameplay_datapath #(
    .SCREEN_W      (SCREEN_W),
    .BLOCK_W       (BLOCK_W),
    .ROW_H         (ROW_H),
    .N_ROWS        (N_ROWS),
    .Y_BASE        (Y_BASE),
    .START_CHANCES (START_CHANCES),
    .TICK_DIV      (TICK_DIV)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .dp     (dp_if)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural model: position moves then reflects off the playfield walls.
  int m_x, m_y, m_prev, m_row, m_score, m_chances, m_cnt, m_div;
  bit m_right, m_tick;

  function automatic int restart_div(input int score);
    int d;
`ifdef GAMEPLAY_SPEEDUP_EN
    int s;
    s = score / 8;
    if (s > 3) s = 3;
    d = TICK_DIV >> s;
    if (d < 1) d = 1;
`else
    d = TICK_DIV;
`endif
    return d;
  endfunction

  always @(posedge clk or negedge resetn) begin
    int x, cnt, dv, y, prev, row, score, ch;
    bit right, tk, over;
    if (!resetn) begin
      m_x <= 0; m_right <= 1'b1; m_y <= Y_BASE; m_prev <= 0; m_row <= 0;
      m_score <= 0; m_chances <= START_CHANCES; m_cnt <= 0; m_div <= TICK_DIV; m_tick <= 1'b0;
    end else begin
      x = m_x; right = m_right; cnt = m_cnt; dv = m_div; tk = 1'b0;
      y = m_y; prev = m_prev; row = m_row; score = m_score; ch = m_chances;
      over = (m_chances == 0);
      if (dp_if.ld_x || dp_if.ld_d) begin
        if (dp_if.ld_x) begin x = 0; cnt = 0; dv = restart_div(m_score); end
        if (dp_if.ld_d) right = 1'b1;
      end else if (dp_if.enable) begin
        cnt++;
        if (cnt == dv) begin
          cnt = 0;
          dv  = restart_div(m_score);
          tk  = 1'b1;
          x   = right ? x + 1 : x - 1;
          if (x > int'(SCREEN_W - BLOCK_W)) begin x = SCREEN_W - BLOCK_W - 1; right = 1'b0; end
          else if (x < 0) begin x = 1; right = 1'b1; end
        end
      end
      if (dp_if.ld_y) y = Y_BASE - ((over && dp_if.ld_x) ? 0 : m_row) * ROW_H;
      if (dp_if.save_x) prev = m_x;
      if (dp_if.inc_row) row = (m_row + 1) % N_ROWS;
      if (dp_if.inc_score && score < 255) score++;
      if (dp_if.dec_chances && ch > 0) ch--;
      if (over && dp_if.ld_x) begin row = 0; score = 0; ch = START_CHANCES; prev = 0; end
      m_x <= x; m_right <= right; m_cnt <= cnt; m_div <= dv; m_tick <= tk;
      m_y <= y; m_prev <= prev; m_row <= row; m_score <= score; m_chances <= ch;
    end
  end

  function automatic int model_o();
    int d;
    d = m_x - m_prev;
    if (d < 0) d = -d;
    return (d < int'(BLOCK_W)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    #2;
    if (resetn) begin
      chk("x", dp_if.x, m_x);
      chk("y", dp_if.y, m_y);
      chk("prev_x", dp_if.prev_x, m_prev);
      chk("row", dp_if.row, m_row);
      chk("score", dp_if.score, m_score);
      chk("chances", dp_if.chances, m_chances);
      chk("move_tick", dp_if.move_tick, m_tick);
      chk("c", dp_if.c, (m_chances != 0) ? 1 : 0);
      chk("o", dp_if.o, model_o());
    end
  end

  task automatic ctl(input bit lx, input bit ly, input bit ld, input bit sx,
                     input bit ir, input bit is, input bit dc);
    dp_if.ld_x = lx; dp_if.ld_y = ly; dp_if.ld_d = ld; dp_if.save_x = sx;
    dp_if.inc_row = ir; dp_if.inc_score = is; dp_if.dec_chances = dc;
    @(negedge clk);
    dp_if.ld_x = 0; dp_if.ld_y = 0; dp_if.ld_d = 0; dp_if.save_x = 0;
    dp_if.inc_row = 0; dp_if.inc_score = 0; dp_if.dec_chances = 0;
  endtask

  task automatic run_en(input int n);
    dp_if.enable = 1'b1;
    repeat (n) @(negedge clk);
    dp_if.enable = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_x"}, dp_if.x, 0);
    chk({tag, "_y"}, dp_if.y, 112);
    chk({tag, "_prev_x"}, dp_if.prev_x, 0);
    chk({tag, "_row"}, dp_if.row, 0);
    chk({tag, "_score"}, dp_if.score, 0);
    chk({tag, "_chances"}, dp_if.chances, 3);
    chk({tag, "_move_tick"}, dp_if.move_tick, 0);
    chk({tag, "_c"}, dp_if.c, 1);
  endtask

  initial begin
    dp_if.enable = 0;
    ctl_clear();
    #12;
    chk_reset_values("rst");
    chk("rst_o", dp_if.o, 1);
    @(negedge clk);
    resetn = 1'b1;

    run_en(10);
    chk("walk_x5", dp_if.x, 5);
    chk("walk_tick", dp_if.move_tick, 1);

    run_en(38);
    chk("edge_x24", dp_if.x, 24);
    run_en(2);
    chk("bounce_x23", dp_if.x, 23);
    run_en(46);
    chk("left_x0", dp_if.x, 0);
    run_en(2);
    chk("bounce_x1", dp_if.x, 1);

    ctl(1, 0, 1, 0, 0, 0, 0);
    run_en(20);
    ctl(0, 0, 0, 1, 0, 0, 0);
    chk("save_prev10", dp_if.prev_x, 10);
    run_en(14);
    chk("ov_x17", dp_if.x, 17);
    chk("ov17_o", dp_if.o, 1);
    run_en(2);
    chk("ov18_o", dp_if.o, 0);
    ctl(1, 0, 1, 0, 0, 0, 0);
    run_en(4);
    chk("ov_x2", dp_if.x, 2);
    chk("ov2_o", dp_if.o, 0);
    run_en(2);
    chk("ov3_o", dp_if.o, 1);

    ctl(1, 0, 1, 0, 0, 0, 0);
    run_en(24);
    chk("multi_x12", dp_if.x, 12);
    ctl(0, 0, 0, 1, 1, 1, 1);
    ctl(0, 1, 0, 0, 0, 0, 0);
    chk("multi_prev", dp_if.prev_x, 12);
    chk("multi_row", dp_if.row, 1);
    chk("multi_score", dp_if.score, 1);
    chk("multi_chances", dp_if.chances, 2);
    chk("multi_y", dp_if.y, 104);

    repeat (13) ctl(0, 0, 0, 0, 1, 0, 0);
    chk("row14", dp_if.row, 14);
    ctl(0, 0, 0, 0, 1, 0, 0);
    chk("row_wrap", dp_if.row, 0);
    repeat (260) ctl(0, 0, 0, 0, 0, 1, 0);
    chk("score_sat", dp_if.score, 255);

    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) ctl(0, 0, 0, 0, 1, 1, 0);
    repeat (3) ctl(0, 0, 0, 0, 0, 0, 1);
    chk("ch_zero", dp_if.chances, 0);
    chk("c_zero", dp_if.c, 0);
    ctl(0, 0, 0, 0, 0, 0, 1);
    chk("ch_sat0", dp_if.chances, 0);
    ctl(1, 1, 1, 0, 0, 0, 0);
    chk("ng_row", dp_if.row, 0);
    chk("ng_score", dp_if.score, 0);
    chk("ng_chances", dp_if.chances, 3);
    chk("ng_y", dp_if.y, 112);
    chk("ng_x", dp_if.x, 0);

    run_en(18);
    repeat (4) ctl(0, 0, 0, 0, 0, 1, 0);
    chk("pre_rst_x9", dp_if.x, 9);
    chk("pre_rst_score4", dp_if.score, 4);
    dp_if.enable = 1'b1;
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_values("async");
    @(negedge clk);
    dp_if.enable = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  task automatic ctl_clear();
    dp_if.ld_x = 0; dp_if.ld_y = 0; dp_if.ld_d = 0; dp_if.save_x = 0;
    dp_if.inc_row = 0; dp_if.inc_score = 0; dp_if.dec_chances = 0;
  endtask

endmodule
